// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage for a synchronous FIFO: pops one word at a time and sends it
//   on a UART TX line, LSB first, one start bit, one stop bit.
//
//   Optional feature macro: FIFO_UART_TX_PARITY_EN
//     undefined : 8N1 frame, DATA goes straight to STOP
//     defined   : 8E1 frame, an even-parity bit sits between data and stop
//
//   Parameters
//     DATA_BITS     width of the FIFO word / frame data field
//     CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//
//   Ports
//     clk         system clock (shared with the FIFO)
//     rst_n       asynchronous active-low reset
//     fifo_empty  FIFO empty flag, only looked at in IDLE
//     fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en  single-cycle read strobe, high only in FETCH
//     tx          serial output, registered, idles high
//     busy        high whenever the FSM is not in IDLE
module fifo_uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, STOP
    } state_t;
`endif

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shift;
    logic [DATA_BITS-1:0]  shift_nx;
    logic                  baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is taken from the word at capture time; the shift register is
    // consumed by the time the parity bit goes out.
    logic                  parity;
`endif

    assign baud_end = (baud_cnt == BAUD_MAX);
    assign shift_nx = shift >> 1;
    assign busy     = (state != IDLE);

    // tx is loaded one cycle ahead with the value of the bit that starts on
    // the next cycle, so the line comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    // FIFO read data is valid now, one cycle after the strobe.
                    shift    <= fifo_data;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity   <= ^fifo_data;
`endif
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift_nx;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx <= shift_nx[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx         <= 1'b1;
                    fifo_rd_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Two instances: dut_a (CLKS_PER_BIT=4) for the directed cycle-exact
//   checks, dut_b (CLKS_PER_BIT=7) for the random-rate stream decoded by a
//   UART receiver model. Each DUT reads from its own behavioural FIFO.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB_A = 4;
    localparam int CPB_B = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- FIFO model A ----------------
    logic [7:0] a_mem [256];
    int         a_wr = 0;
    int         a_rd = 0;
    logic [7:0] a_q = 8'h00;
    logic       a_empty;
    logic       a_rd_en, a_tx, a_busy;
    int         a_pulses = 0;
    assign a_empty = (a_wr == a_rd);
    always @(posedge clk) begin
        if (a_rd_en && !a_empty) begin
            a_q  <= a_mem[a_rd[7:0]];
            a_rd <= a_rd + 1;
        end
        if (a_rd_en) a_pulses <= a_pulses + 1;
    end

    // ---------------- FIFO model B ----------------
    logic [7:0] b_mem [256];
    int         b_wr = 0;
    int         b_rd = 0;
    logic [7:0] b_q = 8'h00;
    logic       b_empty;
    logic       b_rd_en, b_tx, b_busy;
    int         b_pulses = 0;
    assign b_empty = (b_wr == b_rd);
    always @(posedge clk) begin
        if (b_rd_en && !b_empty) begin
            b_q  <= b_mem[b_rd[7:0]];
            b_rd <= b_rd + 1;
        end
        if (b_rd_en) b_pulses <= b_pulses + 1;
    end

    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_empty(a_empty), .fifo_data(a_q),
        .fifo_rd_en(a_rd_en), .tx(a_tx), .busy(a_busy)
    );

    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_empty(b_empty), .fifo_data(b_q),
        .fifo_rd_en(b_rd_en), .tx(b_tx), .busy(b_busy)
    );

    // UART receiver on dut_b: samples the middle of each bit.
    logic [7:0] rcv_b [$];
    int         stop_err_b = 0;
    always begin
        @(negedge clk);
        if (rst_n && b_tx == 1'b0) begin
            logic [7:0] d;
            d = 8'h00;
            repeat (CPB_B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB_B) @(negedge clk);
                d[i] = b_tx;
            end
`ifdef FIFO_UART_TX_PARITY_EN
            repeat (CPB_B) @(negedge clk);
`endif
            repeat (CPB_B) @(negedge clk);
            if (b_tx !== 1'b1) stop_err_b = stop_err_b + 1;
            rcv_b.push_back(d);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        a_mem[a_wr[7:0]] = d;
        a_wr = a_wr + 1;
    endtask

    task automatic push_b(input logic [7:0] d);
        b_mem[b_wr[7:0]] = d;
        b_wr = b_wr + 1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Call at the negedge of the first start-bit cycle; returns at the
    // negedge right after the last stop-bit cycle.
    task automatic expect_frame(input logic [7:0] d, input string tag);
        logic [10:0] got;
        logic        first;
        int          bad;
        got = '0;
        bad = 0;
        chk({tag, "_busy"}, 32'(a_busy), 32'd1);
        for (int b = 0; b < NB; b++) begin
            first  = a_tx;
            got[b] = first;
            for (int c = 0; c < CPB_A; c++) begin
                if (a_tx !== first) bad++;
                @(negedge clk);
            end
        end
        chk({tag, "_bits"}, 32'(got), 32'(frame_bits(d)));
        chk({tag, "_hold"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad_tx, bad_busy, p0, gap;
        logic [7:0] exp_b [$];

        // ---- reset / idle ----
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx", 32'(a_tx), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_rd_en", 32'(a_rd_en), 32'd0);
        rst_n = 1'b1;
        bad_tx = 0;
        bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (a_tx !== 1'b1) bad_tx++;
            if (a_busy !== 1'b0) bad_busy++;
        end
        chk("idle_tx", 32'(bad_tx), 32'd0);
        chk("idle_busy", 32'(bad_busy), 32'd0);
        chk("idle_pulses", 32'(a_pulses), 32'd0);

        // ---- single byte 0x55 ----
        p0 = a_pulses;
        push_a(8'h55);
        @(negedge clk);
        chk("s55_rd_en", 32'(a_rd_en), 32'd1);
        @(negedge clk);
        chk("s55_rd_en_off", 32'(a_rd_en), 32'd0);
        chk("s55_load_tx", 32'(a_tx), 32'd1);
        @(negedge clk);
        expect_frame(8'h55, "s55");
        chk("s55_busy_end", 32'(a_busy), 32'd0);
        chk("s55_pulses", 32'(a_pulses - p0), 32'd1);

        // ---- back-to-back 0xA3, 0x0F ----
        p0 = a_pulses;
        push_a(8'hA3);
        push_a(8'h0F);
        repeat (3) @(negedge clk);
        expect_frame(8'hA3, "b2b_a3");
        gap = 0;
        while (a_tx === 1'b1 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("b2b_gap", 32'(gap), 32'd3);
        expect_frame(8'h0F, "b2b_0f");
        chk("b2b_empty", 32'(a_empty), 32'd1);
        chk("b2b_pulses", 32'(a_pulses - p0), 32'd2);

`ifdef FIFO_UART_TX_PARITY_EN
        // ---- parity bit values ----
        push_a(8'h07);
        repeat (3) @(negedge clk);
        expect_frame(8'h07, "par07");
        chk("par07_idle", 32'(a_busy), 32'd0);
        push_a(8'h03);
        repeat (3) @(negedge clk);
        expect_frame(8'h03, "par03");
`endif

        // ---- reset during the 3rd data bit of 0xFF ----
        push_a(8'hFF);
        push_a(8'h5A);
        repeat (3) @(negedge clk);
        // start occupies 4 cycles, bits 0/1 another 8; +1 lands inside bit 2
        repeat (CPB_A * 3 + 1) @(negedge clk);
        chk("mid_pre_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_tx", 32'(a_tx), 32'd1);
        chk("mid_busy", 32'(a_busy), 32'd0);
        chk("mid_rd_en", 32'(a_rd_en), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rd_en_again", 32'(a_rd_en), 32'd1);
        repeat (2) @(negedge clk);
        expect_frame(8'h5A, "mid_5a");
        chk("mid_empty", 32'(a_empty), 32'd1);

        // ---- stress on dut_b: 64 bytes at random rates ----
        for (int i = 0; i < 64; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            exp_b.push_back(v);
            push_b(v);
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        for (int t = 0; t < 20000 && rcv_b.size() < 64; t++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("stress_count", 32'(rcv_b.size()), 32'd64);
        chk("stress_pulses", 32'(b_pulses), 32'd64);
        chk("stress_stop", 32'(stop_err_b), 32'd0);
        chk("stress_empty", 32'(b_empty), 32'd1);
        for (int i = 0; i < 64; i++) begin
            if (i < rcv_b.size()) chk($sformatf("stress_byte%0d", i), 32'(rcv_b[i]), 32'(exp_b[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain stage that sits directly downstream of the synchronous FIFO. It pops one byte at a time through the FIFO's read port and shifts it out on a single UART TX line as an 8N1 frame, LSB first, at a fixed baud set by a clock-divider parameter. It is the FIFO's only reader, so it never races another consumer for `empty`.

## Interface
Parameters:
- `DATA_BITS`, default 8: width of the FIFO word and of the frame's data field.
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, shared with the FIFO.
- `rst_n` in 1: asynchronous active-low reset.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in `DATA_BITS`: FIFO `data_out`. Registered in the FIFO and valid the cycle after an accepted read.
- `fifo_rd_en` out 1: read strobe to the FIFO; single-cycle pulse.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (only when the parity macro is defined), STOP.
- **IDLE:** `tx`=1. If `fifo_empty`=0, go to FETCH. Otherwise stay in IDLE.
- **FETCH:** `fifo_rd_en`=1 for exactly this one cycle, then go to LOAD. `fifo_rd_en` is a Moore output and is 0 in every other state.
- **LOAD:** at the end of this cycle, capture `fifo_data` into the shift register, clear the bit counter, clear the baud counter, then go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles.
- **DATA:** `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After `DATA_BITS` bits, go to PARITY if enabled, otherwise STOP.
- **PARITY:** `tx`=even parity (XOR of the captured word) for `CLKS_PER_BIT` cycles.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.

Counters:
- Baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0 to `CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
- Bit counter is `$clog2(DATA_BITS)+1` bits wide.

Outputs:
- `tx` is driven from a register, so it is glitch-free.
- `busy` = (state ≠ IDLE).

## Timing
Reset values (asynchronous, on `rst_n`=0): state IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, all counters 0, shift register 0.

Latency:
- `fifo_empty` observed low at IDLE in cycle N → `fifo_rd_en` high in cycle N+1.
- Data is captured at the end of cycle N+2.
- Start bit's first cycle on `tx` is cycle N+3.

Frame length: (`DATA_BITS`+2) × `CLKS_PER_BIT` cycles; +`CLKS_PER_BIT` with parity.

Back-to-back frames: exactly 3 `clk` cycles of `tx`=1 (IDLE, FETCH, LOAD) between the last STOP cycle and the next start bit.

Boundary conditions:
- **Empty FIFO:** `fifo_empty` is sampled only in IDLE. Because this block is the sole reader, the FIFO cannot go empty between IDLE and FETCH. Writes during a frame do not affect the frame.
- **Full FIFO:** no special behaviour. The upstream writer stalls on `full`.
- **Reset mid-frame:** `tx` returns to 1 immediately and the in-flight byte is dropped. A byte already popped in FETCH is lost; this is acceptable.
- **`fifo_empty` toggling in non-IDLE states:** ignored.

## Configuration
- Macro `FIFO_UART_TX_PARITY_EN`.
  - **Defined:** the PARITY state is compiled in. Frame becomes 8E1: one even-parity bit between the data and stop bits, frame length (`DATA_BITS`+3) × `CLKS_PER_BIT`.
  - **Undefined:** the PARITY state and its logic are absent, giving an 8N1 frame. DATA transitions directly to STOP.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DATA_BITS`=8 unless noted.
- **Reset/idle:** hold `rst_n`=0 for 5 cycles, release, keep `fifo_empty`=1 for 100 cycles → `tx`=1, `busy`=0, and `fifo_rd_en` is never asserted.
- **Single byte:** FIFO holds 0x55 → one `fifo_rd_en` pulse, then `tx` sequence 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles (40 cycles total), then `busy`=0.
- **Back-to-back:** FIFO holds 0xA3 then 0x0F → two `fifo_rd_en` pulses; decoded bytes are 0xA3 then 0x0F; exactly 3 high cycles between the end of the first STOP and the second start bit; FIFO ends empty.
- **Parity (macro defined):** send 0x07 → parity bit 1 and frame length 44 cycles. Send 0x03 → parity bit 0.
- **Reset mid-frame:** assert `rst_n`=0 during the 3rd data bit of 0xFF → `tx`=1 in the same cycle and state IDLE. After release with the FIFO still non-empty, the next byte transmits correctly.
- **Stress:** 64 random bytes pushed at random rates with `CLKS_PER_BIT`=7 → the UART monitor receives the identical sequence, and the count of `fifo_rd_en` pulses equals 64.
